// File: rtl/fsm_traffic_pkg.sv
// rtl/fsm_traffic_pkg.sv - shared state, light codes and phase duration helpers
package fsm_traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_2  = 3'd5,
        WALK      = 3'd6
    } state_e;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Unused codes time out like an all-red clearance.
    function automatic int dur_sel(input state_e s, input int g, input int y,
                                   input int ar, input int w);
        case (s)
            NS_GREEN, EW_GREEN:   return g;
            NS_YELLOW, EW_YELLOW: return y;
            WALK:                 return w;
            default:              return ar;
        endcase
    endfunction

endpackage

// File: rtl/fsm_traffic_ctrl_phase_timer.sv
// rtl/fsm_traffic_ctrl_phase_timer.sv - loadable down-counter flagging phase expiry
module phase_timer #(
    parameter int CNT_W   = 4,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holding at zero keeps a one-cycle phase from wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/fsm_traffic_ctrl.sv
// rtl/fsm_traffic_ctrl.sv - two-road intersection Moore FSM with pedestrian walk phase
module fsm_traffic_ctrl
    import fsm_traffic_pkg::*;
#(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 5,
    parameter int CNT_W      = $clog2(max4(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, WALK_CYC)) + 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       ped_req,
    output logic [1:0] light_ns,
    output logic [1:0] light_ew,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state_o
);

    state_e           state_q, state_d;
    dir_e             next_dir_q, next_dir_d;
    logic             ped_pending_q, ped_pending_d;
    logic             expired;
    logic             load;
    logic [CNT_W-1:0] load_val;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_CYC - 1)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        if (en) begin
            case (state_q)
                NS_GREEN:  if (expired) state_d = NS_YELLOW;
                NS_YELLOW: if (expired) state_d = ALLRED_1;
                ALLRED_1: if (expired) begin
                    next_dir_d = DIR_EW;
                    state_d    = ped_pending_q ? WALK : EW_GREEN;
                end
                EW_GREEN:  if (expired) state_d = EW_YELLOW;
                EW_YELLOW: if (expired) state_d = ALLRED_2;
                ALLRED_2: if (expired) begin
                    next_dir_d = DIR_NS;
                    state_d    = ped_pending_q ? WALK : NS_GREEN;
                end
                WALK: if (expired) state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
                default: state_d = ALLRED_2;
            endcase
        end
        // No state loops to itself, so any change of state is a phase entry.
        load          = (state_d != state_q);
        load_val      = CNT_W'(dur_sel(state_d, GREEN_CYC, YELLOW_CYC, ALLRED_CYC, WALK_CYC) - 1);
        ped_pending_d = ped_req | (ped_pending_q & ~(load & (state_d == WALK)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ALLRED_2;
            next_dir_q    <= DIR_NS;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        light_ns = LIGHT_RED;
        light_ew = LIGHT_RED;
        walk     = 1'b0;
        case (state_q)
            NS_GREEN:  light_ns = LIGHT_GREEN;
            NS_YELLOW: light_ns = LIGHT_YELLOW;
            EW_GREEN:  light_ew = LIGHT_GREEN;
            EW_YELLOW: light_ew = LIGHT_YELLOW;
            WALK:      walk     = 1'b1;
            default: ;
        endcase
    end

    assign ped_pending = ped_pending_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fsm_traffic_ctrl.sv
// tb/tb_fsm_traffic_ctrl.sv - directed vector bench for fsm_traffic_ctrl
module tb_fsm_traffic_ctrl;
    import fsm_traffic_pkg::*;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;

    typedef struct packed {
        logic       ped;
        logic       en;
        logic [1:0] ns;
        logic [1:0] ew;
        logic       wlk;
        logic       pend;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, en, ped_req;
    logic [1:0] light_ns, light_ew;
    logic       walk, ped_pending;
    logic [2:0] state_o;

    logic       rst2_n, en2, ped2;
    logic [1:0] ns2, ew2;
    logic       walk2, pend2;
    logic [2:0] state2;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fsm_traffic_ctrl dut (
        .clk(clk), .reset_n(reset_n), .en(en), .ped_req(ped_req),
        .light_ns(light_ns), .light_ew(light_ew), .walk(walk),
        .ped_pending(ped_pending), .state_o(state_o)
    );

    fsm_traffic_ctrl #(
        .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .WALK_CYC(1)
    ) dut_min (
        .clk(clk), .reset_n(rst2_n), .en(en2), .ped_req(ped2),
        .light_ns(ns2), .light_ew(ew2), .walk(walk2),
        .ped_pending(pend2), .state_o(state2)
    );

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int n, input logic p, input logic e, input logic [1:0] ns,
                       input logic [1:0] ew, input logic w, input logic pd);
        vec_t v;
        v = '{ped: p, en: e, ns: ns, ew: ew, wlk: w, pend: pd};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic chk_outs(input string tag, input int idx, input vec_t v);
        chk({tag, "_ns"},   idx, {6'd0, light_ns}, {6'd0, v.ns});
        chk({tag, "_ew"},   idx, {6'd0, light_ew}, {6'd0, v.ew});
        chk({tag, "_walk"}, idx, {7'd0, walk},     {7'd0, v.wlk});
        chk({tag, "_pend"}, idx, {7'd0, ped_pending}, {7'd0, v.pend});
    endtask

    initial begin
        logic [2:0] min_st [8];
        logic [1:0] min_ns [8];
        logic [1:0] min_ew [8];

        reset_n = 1'b0; en = 1'b1; ped_req = 1'b0;
        rst2_n  = 1'b0; en2 = 1'b1; ped2 = 1'b0;

        // k=1: remaining all-red after release; two full rings follow
        add(1, 0, 1, R, R, 0, 0);
        for (int r = 0; r < 2; r++) begin
            add(8, 0, 1, G, R, 0, 0);
            add(3, 0, 1, Y, R, 0, 0);
            add(2, 0, 1, R, R, 0, 0);
            add(8, 0, 1, R, G, 0, 0);
            add(3, 0, 1, R, Y, 0, 0);
            add(2, 0, 1, R, R, 0, 0);
        end
        // single pedestrian request during NS green
        add(1, 0, 1, G, R, 0, 0);
        add(1, 1, 1, G, R, 0, 1);
        add(6, 0, 1, G, R, 0, 1);
        add(3, 0, 1, Y, R, 0, 1);
        add(2, 0, 1, R, R, 0, 1);
        add(5, 0, 1, R, R, 1, 0);
        add(8, 0, 1, R, G, 0, 0);
        add(3, 0, 1, R, Y, 0, 0);
        add(2, 0, 1, R, R, 0, 0);
        // request coincident with WALK entry stays pending for the next all-red
        add(1, 0, 1, G, R, 0, 0);
        add(1, 1, 1, G, R, 0, 1);
        add(6, 0, 1, G, R, 0, 1);
        add(3, 0, 1, Y, R, 0, 1);
        add(2, 0, 1, R, R, 0, 1);
        add(1, 1, 1, R, R, 1, 1);
        add(4, 0, 1, R, R, 1, 1);
        add(8, 0, 1, R, G, 0, 1);
        add(3, 0, 1, R, Y, 0, 1);
        add(2, 0, 1, R, R, 0, 1);
        add(5, 0, 1, R, R, 1, 0);
        // freeze with 4 green cycles remaining, request latched while frozen
        add(4, 0, 1, G, R, 0, 0);
        add(4, 0, 0, G, R, 0, 0);
        add(1, 1, 0, G, R, 0, 1);
        add(5, 0, 0, G, R, 0, 1);
        add(4, 0, 1, G, R, 0, 1);
        add(3, 0, 1, Y, R, 0, 1);
        add(2, 0, 1, R, R, 0, 1);
        add(5, 0, 1, R, R, 1, 0);
        add(8, 0, 1, R, G, 0, 0);
        add(1, 0, 1, R, Y, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_hold_ns", 0, {6'd0, light_ns}, 8'h00);
        chk("rst_hold_state", 0, {5'd0, state_o}, {5'd0, ALLRED_2});
        reset_n = 1'b1;
        #1;
        chk_outs("rel", 0, '{ped: 0, en: 1, ns: R, ew: R, wlk: 0, pend: 0});

        foreach (vecs[i]) begin
            ped_req = vecs[i].ped;
            en      = vecs[i].en;
            @(posedge clk);
            @(negedge clk);
            chk_outs("vec", i + 1, vecs[i]);
        end
        ped_req = 1'b0;
        en      = 1'b1;

        // asynchronous reset mid EW yellow, sampled before the next rising edge
        #2 reset_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, '{ped: 0, en: 1, ns: R, ew: R, wlk: 0, pend: 0});
        chk("async_rst_state", 0, {5'd0, state_o}, {5'd0, ALLRED_2});

        // all durations 1: six-state ring, one cycle each
        min_st = '{ALLRED_2, NS_GREEN, NS_YELLOW, ALLRED_1, EW_GREEN, EW_YELLOW, ALLRED_2, NS_GREEN};
        min_ns = '{R, G, Y, R, R, R, R, G};
        min_ew = '{R, R, R, R, G, Y, R, R};
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk("min_state", k, {5'd0, state2}, {5'd0, min_st[k]});
            chk("min_ns",    k, {6'd0, ns2},    {6'd0, min_ns[k]});
            chk("min_ew",    k, {6'd0, ew2},    {6'd0, min_ew[k]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
